fpu_issue_controller: RTL

//  Initiator side of the Fixed_Point_Unit operand/operation/result/ready interface.

---
 rtl/fpu_pkg.sv | 23 ++
 rtl/fpu_wait_timer.sv | 44 ++++
 rtl/fpu_issue_controller.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg
//  Shared definitions for the fixed-point unit issue path:
//  - FPU opcode encodings driven on fpu_operation
//  - default operand width and fractional-bit count
//  - 2-bit state encoding of the issue FSM
package fpu_pkg;

    localparam int FPU_WIDTH_DEF = 32;
    localparam int FPU_FBITS_DEF = 10;

    localparam logic [1:0] FPU_ADD  = 2'b00;
    localparam logic [1:0] FPU_SUB  = 2'b01;
    localparam logic [1:0] FPU_MUL  = 2'b10;
    localparam logic [1:0] FPU_SQRT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } issue_state_e;

endpackage

// File: rtl/fpu_wait_timer.sv
// fpu_wait_timer
//  Loadable up-counter with a terminal-count flag. The issue controller reuses
//  one instance for both the settle window and the ready timeout.
// Ports
//  clk    in   rising-edge clock
//  reset  in   asynchronous, active-high; clears the count
//  load   in   clear the count to 0 on the next edge (wins over en)
//  en     in   increment the count on the next edge
//  limit  in   terminal value compared against the current count
//  tc     out  1 while the current count equals limit
module fpu_wait_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == limit);

endmodule

// File: rtl/fpu_issue_controller.sv
// fpu_issue_controller
//  Initiator side of the fixed-point unit interface. Takes an op request from
//  execute (valid/ready), drives and holds operands/opcode to the FPU, ignores
//  fpu_ready for a settle window, then waits (bounded) for fpu_ready and hands
//  the captured result plus tag to writeback (valid/ready).
// Ports
//  clk, reset                      clock, asynchronous active-high reset
//  req_valid/req_ready             request handshake from execute
//  req_op, req_a, req_b, req_tag   opcode, operands, destination tag
//  fpu_operand_1/2, fpu_operation  registered drive to the FPU
//  fpu_result, fpu_ready           FPU result and level-sensitive valid
//  rsp_valid/rsp_ready             response handshake to writeback
//  rsp_result, rsp_tag, rsp_err    response payload (result 0 on error)
//  busy                            controller not idle
module fpu_issue_controller
    import fpu_pkg::*;
#(
    parameter int WIDTH   = FPU_WIDTH_DEF,
    parameter int FBITS   = FPU_FBITS_DEF,
    parameter int TAG_W   = 5,
    parameter int SETTLE  = 1,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] fpu_operand_1,
    output logic [WIDTH-1:0] fpu_operand_2,
    output logic [1:0]       fpu_operation,
    input  logic [WIDTH-1:0] fpu_result,
    input  logic             fpu_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             busy
);

    // One counter serves both windows, so size it for the longer one.
    localparam int CNT_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    if (SETTLE < 1 || TIMEOUT < 2 || FBITS >= WIDTH) begin : g_param_check
        $error("fpu_issue_controller: illegal SETTLE/TIMEOUT/FBITS");
    end

    issue_state_e     state_q, state_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic [1:0]       opc_q, opc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             err_q, err_d;

    logic             accept;
    logic             tmr_load;
    logic             tmr_en;
    logic             tmr_tc;
    logic [CNT_W-1:0] tmr_limit;

    assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
    assign accept    = req_valid && req_ready;

    // ISSUE counts 0..SETTLE-1, WAIT counts 0..TIMEOUT-1.
    assign tmr_limit = (state_q == ST_ISSUE) ? CNT_W'(SETTLE - 1) : CNT_W'(TIMEOUT - 1);

    fpu_wait_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .en    (tmr_en),
        .limit (tmr_limit),
        .tc    (tmr_tc)
    );

    always_comb begin
        state_d  = state_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        opc_d    = opc_q;
        result_d = result_q;
        tag_d    = tag_q;
        err_d    = err_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;

        if (accept) begin
            // An accept also covers the back-to-back case from RESP.
            tag_d = req_tag;
            if ((req_op == FPU_SQRT) && req_a[WIDTH-1]) begin
                // Negative SQRT is rejected locally; the FPU never sees it.
                state_d  = ST_RESP;
                err_d    = 1'b1;
                result_d = '0;
            end else begin
                op1_d    = req_a;
                op2_d    = req_b;
                opc_d    = req_op;
                state_d  = ST_ISSUE;
                tmr_load = 1'b1;
            end
        end else begin
            unique case (state_q)
                ST_ISSUE: begin
                    // fpu_ready may still reflect the previous op here.
                    if (tmr_tc) begin
                        state_d  = ST_WAIT;
                        tmr_load = 1'b1;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                ST_WAIT: begin
                    // Ready is checked first so a result on the last cycle wins.
                    if (fpu_ready) begin
                        result_d = fpu_result;
                        err_d    = 1'b0;
                        state_d  = ST_RESP;
                    end else if (tmr_tc) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op1_q    <= '0;
            op2_q    <= '0;
            opc_q    <= FPU_ADD;
            result_q <= '0;
            tag_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            opc_q    <= opc_d;
            result_q <= result_d;
            tag_q    <= tag_d;
            err_q    <= err_d;
        end
    end

    assign fpu_operand_1 = op1_q;
    assign fpu_operand_2 = op2_q;
    assign fpu_operation = opc_q;
    assign rsp_valid     = (state_q == ST_RESP);
    assign rsp_result    = result_q;
    assign rsp_tag       = tag_q;
    assign rsp_err       = err_q;
    assign busy          = (state_q != ST_IDLE);

endmodule
